// File: rtl/rdat_separator.sv
// rdat_separator: floppy read-path data separator.
// Re-times raw drive pulses (rdat_n) into vg_rawr strobes and generates the
// vg_rclk read window with a phase- and frequency-tracking window counter.
// It also reports a lock status.
module rdat_separator #(
  parameter int WIN_MFM  = 56,
  parameter int WIN_FM   = 112,
  parameter int RAWR_W   = 4,
  parameter int FOFF_MAX = 3,
  parameter int LOCK_CNT = 16,
  parameter int IDLE_WIN = 64
) (
  input  logic fclk,
  input  logic rst,
  input  logic rdat_n,
  input  logic mfm,
  output logic vg_rclk,
  output logic vg_rawr,
  output logic locked
);

  localparam int RW = $clog2(RAWR_W + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int IW = $clog2(IDLE_WIN + 1);

  localparam logic [7:0]        BASE_MFM  = 8'(WIN_MFM);
  localparam logic [7:0]        BASE_FM   = 8'(WIN_FM);
  localparam logic [RW-1:0]     RAWR_LOAD = RW'(RAWR_W);
  localparam logic [GW-1:0]     GOOD_MAX  = GW'(LOCK_CNT);
  localparam logic [IW-1:0]     IDLE_MAX  = IW'(IDLE_WIN);
  localparam logic signed [4:0] FLIM_MFM  = 5'(FOFF_MAX);
  localparam logic signed [4:0] FLIM_FM   = 5'(2 * FOFF_MAX);
  localparam logic signed [8:0] FTHR_MFM  = 9'sd3;
  localparam logic signed [8:0] FTHR_FM   = 9'sd6;
  localparam logic [8:0]        GOOD_MFM  = 9'd4;
  localparam logic [8:0]        GOOD_FM   = 9'd8;
  localparam logic [8:0]        BAD_MFM   = 9'd12;
  localparam logic [8:0]        BAD_FM    = 9'd24;

  // State registers
  logic [2:0]        s_q, s_d;
  logic              det_q, det_d;
  logic              mfm_q, mfm_d;
  logic [7:0]        cnt_q, cnt_d;
  logic signed [4:0] foff_q, foff_d;
  logic [GW-1:0]     good_q, good_d;
  logic              locked_q, locked_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic [RW-1:0]     rawr_cnt_q, rawr_cnt_d;
  logic              rclk_q, rclk_d;

  // Combinational helpers
  logic              det;
  logic [7:0]        base;
  logic [7:0]        per;
  logic [7:0]        c_val;
  logic signed [8:0] err;
  logic [8:0]        abs_err;
  logic signed [4:0] flim;
  logic signed [8:0] fthr;
  logic [8:0]        good_thr;
  logic [8:0]        bad_thr;
  logic              mode_chg;
  logic              accept;
  logic              wrap;

  // All state registers; the mode copy resets to MFM.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      s_q        <= 3'b111;
      det_q      <= 1'b0;
      mfm_q      <= 1'b1;
      cnt_q      <= 8'd0;
      foff_q     <= 5'sd0;
      good_q     <= '0;
      locked_q   <= 1'b0;
      idle_q     <= '0;
      rawr_cnt_q <= '0;
      rclk_q     <= 1'b0;
    end else begin
      s_q        <= s_d;
      det_q      <= det_d;
      mfm_q      <= mfm_d;
      cnt_q      <= cnt_d;
      foff_q     <= foff_d;
      good_q     <= good_d;
      locked_q   <= locked_d;
      idle_q     <= idle_d;
      rawr_cnt_q <= rawr_cnt_d;
      rclk_q     <= rclk_d;
    end
  end

  // Synchronise rdat_n and detect its falling edge; det is retimed once more
  // so the pulse acts three edges after the first low sample.
  always_comb begin
    s_d   = {s_q[1:0], rdat_n};
    det   = s_q[2] & ~s_q[1];
    det_d = det;
  end

  // Window geometry and pulse phase error for the current mode and offset.
  always_comb begin
    base     = mfm_q ? BASE_MFM : BASE_FM;
    per      = base + 8'(foff_q);
    c_val    = {1'b0, per[7:1]};
    err      = $signed({1'b0, cnt_q}) - $signed({1'b0, c_val});
    abs_err  = err[8] ? $unsigned(-err) : $unsigned(err);
    flim     = mfm_q ? FLIM_MFM : FLIM_FM;
    fthr     = mfm_q ? FTHR_MFM : FTHR_FM;
    good_thr = mfm_q ? GOOD_MFM : GOOD_FM;
    bad_thr  = mfm_q ? BAD_MFM  : BAD_FM;
  end

  // Tracker next state: mode change, accepted pulse, window wrap, idle drop.
  always_comb begin
    cnt_d      = cnt_q;
    foff_d     = foff_q;
    good_d     = good_q;
    locked_d   = locked_q;
    idle_d     = idle_q;
    rawr_cnt_d = rawr_cnt_q;
    rclk_d     = rclk_q;
    mfm_d      = mfm;

    mode_chg = (mfm != mfm_q);
    accept   = det_q & (rawr_cnt_q == '0) & ~mode_chg;
    wrap     = (cnt_q == per - 8'd1);

    if (mode_chg) begin
      // Restart tracking in the new mode; rclk keeps its level.
      cnt_d      = 8'd0;
      foff_d     = 5'sd0;
      good_d     = '0;
      locked_d   = 1'b0;
      idle_d     = '0;
      rawr_cnt_d = '0;
    end else begin
      if (rawr_cnt_q != '0) begin
        rawr_cnt_d = rawr_cnt_q - RW'(1);
      end

      if (accept) begin
        // Pull the window halfway toward centring the pulse; never wraps.
        cnt_d = cnt_q + 8'd1 - 8'(err >>> 1);

        if ((err >= fthr) && (foff_q < flim)) begin
          foff_d = foff_q + 5'sd1;
        end else if ((err <= -fthr) && (foff_q > -flim)) begin
          foff_d = foff_q - 5'sd1;
        end

        if (abs_err <= good_thr) begin
          if (good_q != GOOD_MAX) begin
            good_d = good_q + GW'(1);
          end
          if (good_d == GOOD_MAX) begin
            locked_d = 1'b1;
          end
        end else if (abs_err > bad_thr) begin
          good_d   = '0;
          locked_d = 1'b0;
        end

        idle_d     = '0;
        rawr_cnt_d = RAWR_LOAD;
      end else if (wrap) begin
        cnt_d  = 8'd0;
        rclk_d = ~rclk_q;
        if (idle_q != IDLE_MAX) begin
          idle_d = idle_q + IW'(1);
        end
      end else begin
        cnt_d = cnt_q + 8'd1;
      end

      // Long silence: forget frequency and lock until pulses return.
      if (idle_d == IDLE_MAX) begin
        foff_d   = 5'sd0;
        good_d   = '0;
        locked_d = 1'b0;
      end
    end
  end

  assign vg_rclk = rclk_q;
  assign vg_rawr = (rawr_cnt_q != '0);
  assign locked  = locked_q;

endmodule

// File: tb/tb_rdat_separator.sv
// Testbench for rdat_separator: randomized pulse trains checked every cycle
// against a behavioural model, plus directed latency/reset/mode checks.
module tb_rdat_separator;

  localparam int WIN_MFM  = 56;
  localparam int WIN_FM   = 112;
  localparam int RAWR_W   = 4;
  localparam int FOFF_MAX = 3;
  localparam int LOCK_CNT = 16;
  localparam int IDLE_WIN = 64;

  logic fclk = 1'b0;
  logic rst;
  logic rdat_n;
  logic mfm;
  logic vg_rclk;
  logic vg_rawr;
  logic locked;

  rdat_separator #(
    .WIN_MFM(WIN_MFM), .WIN_FM(WIN_FM), .RAWR_W(RAWR_W),
    .FOFF_MAX(FOFF_MAX), .LOCK_CNT(LOCK_CNT), .IDLE_WIN(IDLE_WIN)
  ) dut (
    .fclk(fclk), .rst(rst), .rdat_n(rdat_n), .mfm(mfm),
    .vg_rclk(vg_rclk), .vg_rawr(vg_rawr), .locked(locked)
  );

  always #5 fclk = ~fclk;

  int    n_cmp = 0;
  int    n_bad = 0;
  string tag = "init";

  // Behavioural model state
  int m_cnt, m_foff, m_good, m_idle, m_rawr_left, m_edge;
  bit m_rclk, m_locked, m_mode, m_prev;
  int m_pend[$];

  function automatic int floor_half(input int e);
    return (e >= 0) ? (e / 2) : -((-e + 1) / 2);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_foff = 0; m_good = 0; m_idle = 0; m_rawr_left = 0;
    m_rclk = 0; m_locked = 0; m_mode = 1; m_prev = 1;
    m_pend.delete();
  endtask

  task automatic model_edge(input logic r, input logic m);
    int per, c, err, lim, thr, gthr, bthr, aerr;
    bit cand, acc;
    if (rst) begin
      model_reset();
      m_edge++;
      return;
    end
    cand = 0;
    if (m_pend.size() > 0 && m_pend[0] == m_edge) begin
      cand = 1;
      void'(m_pend.pop_front());
    end
    if (r == 1'b0 && m_prev == 1'b1) m_pend.push_back(m_edge + 3);
    m_prev = r;
    m_edge++;
    if (m != m_mode) begin
      m_mode = m; m_cnt = 0; m_foff = 0; m_good = 0; m_locked = 0;
      m_idle = 0; m_rawr_left = 0;
      return;
    end
    per  = (m_mode ? WIN_MFM : WIN_FM) + m_foff;
    c    = per / 2;
    lim  = m_mode ? FOFF_MAX : 2 * FOFF_MAX;
    thr  = m_mode ? 3 : 6;
    gthr = m_mode ? 4 : 8;
    bthr = m_mode ? 12 : 24;
    acc  = cand && (m_rawr_left == 0);
    if (m_rawr_left > 0) m_rawr_left--;
    if (acc) begin
      err  = m_cnt - c;
      aerr = (err < 0) ? -err : err;
      m_cnt = m_cnt + 1 - floor_half(err);
      if (err >= thr && m_foff < lim) m_foff++;
      else if (err <= -thr && m_foff > -lim) m_foff--;
      if (aerr <= gthr) begin
        if (m_good < LOCK_CNT) m_good++;
        if (m_good == LOCK_CNT) m_locked = 1;
      end else if (aerr > bthr) begin
        m_good = 0; m_locked = 0;
      end
      m_idle = 0;
      m_rawr_left = RAWR_W;
    end else if (m_cnt == per - 1) begin
      m_cnt = 0;
      m_rclk = ~m_rclk;
      if (m_idle < IDLE_WIN) m_idle++;
    end else begin
      m_cnt++;
    end
    if (m_idle == IDLE_WIN) begin
      m_foff = 0; m_good = 0; m_locked = 0;
    end
  endtask

  task automatic check3(input string name, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s edge=%0d observed rclk/rawr/locked=%b expected=%b", name, m_edge, obs, exp);
    end
  endtask

  task automatic check_int(input string name, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", name, m_edge, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare at negedge.
  task automatic tick(input logic r, input logic m);
    rdat_n = r;
    mfm    = m;
    @(posedge fclk);
    model_edge(r, m);
    @(negedge fclk);
    check3(tag, {vg_rclk, vg_rawr, locked}, {m_rclk, (m_rawr_left != 0), m_locked});
  endtask

  // Pulse-free run; when half > 0, every full interval between rclk toggles must equal half.
  task automatic run_free(input int n, input logic m, input int half);
    int last;
    logic prev;
    last = -1;
    prev = vg_rclk;
    for (int i = 0; i < n; i++) begin
      tick(1'b1, m);
      if (vg_rclk !== prev) begin
        if (half > 0 && last >= 0) check_int("rclk_half_period", i - last, half);
        last = i;
        prev = vg_rclk;
      end
    end
  endtask

  // Train of n pulses, period +/- jit, low width 3..5 fclk.
  task automatic pulses(input int n, input int period, input int jit, input logic m);
    int gap, low;
    for (int i = 0; i < n; i++) begin
      gap = period - jit + int'($urandom_range(unsigned'(2 * jit)));
      low = 3 + int'($urandom_range(2));
      for (int t = 0; t < low; t++) tick(1'b0, m);
      for (int t = low; t < gap; t++) tick(1'b1, m);
    end
  endtask

  initial begin
    logic [11:0] pat_v;
    logic [11:0] exp_v;
    bit seen;

    m_edge = 0;
    rst = 1'b1; rdat_n = 1'b1; mfm = 1'b1;
    model_reset();
    #1;
    check3("reset_outputs", {vg_rclk, vg_rawr, locked}, 3'b000);
    tag = "in_reset";
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    rst = 1'b0;

    // Free run after reset: rclk toggles every 56, idle saturates.
    tag = "free_run";
    run_free(65 * WIN_MFM + 20, 1'b1, WIN_MFM);

    // Latency and glitch: 3-cycle pulse, second fall while rawr active.
    tag = "glitch";
    pat_v = 12'b111110001000;
    exp_v = 12'b000001111000;
    for (int i = 0; i < 12; i++) begin
      tick(pat_v[i], 1'b1);
      check_int("rawr_latency", int'(vg_rawr), int'(exp_v[i]));
    end
    run_free(200, 1'b1, 0);

    tag = "phase_acq";
    pulses(40, 112, 1, 1'b1);
    tag = "freq_116";
    pulses(40, 116, 1, 1'b1);
    tag = "freq_130";
    pulses(30, 130, 0, 1'b1);
    tag = "relock";
    pulses(40, 112, 0, 1'b1);

    // Mode switch to FM.
    tag = "mode_switch";
    tick(1'b1, 1'b0);
    check_int("locked_after_switch", int'(locked), 0);
    run_free(600, 1'b0, WIN_FM);
    tag = "fm_lock";
    pulses(24, 224, 1, 1'b0);

    tag = "mfm_back";
    pulses(40, 112, 0, 1'b1);

    // Idle drop after 64 pulse-free windows.
    tag = "idle";
    run_free(64 * 59 + 60, 1'b1, 0);
    check_int("locked_after_idle", int'(locked), 0);
    run_free(400, 1'b1, WIN_MFM);

    // Reset while vg_rawr is high.
    tag = "rst_mid";
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick(1'b1, 1'b1);
      seen = vg_rawr;
    end
    check_int("rawr_seen_before_rst", int'(seen), 1);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check3("rst_mid_outputs", {vg_rclk, vg_rawr, locked}, 3'b000);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    rst = 1'b0;
    tag = "after_rst";
    run_free(300, 1'b1, WIN_MFM);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rdat_separator.md
# rdat_separator

Digital data separator for the floppy read path. It takes the raw asynchronous read-data pulses from the drive (`rdat_n`) and produces the read clock window (`vg_rclk`) and re-timed read pulses (`vg_rawr`) that feed the VG93 read inputs. It uses a phase-and-frequency tracking window counter clocked at 28 MHz `fclk`, and reports a lock indication for debug/status.

## Interface
Parameters:
- `WIN_MFM`, 56: window length in fclk for MFM (2 us; vg_rclk period 4 us).
- `WIN_FM`, 112: window length for FM (4 us).
- `RAWR_W`, 4: vg_rawr pulse width in fclk.
- `FOFF_MAX`, 3: MFM frequency-offset clamp in fclk; FM uses 2*FOFF_MAX.
- `LOCK_CNT`, 16: consecutive good pulses needed to assert locked.
- `IDLE_WIN`, 64: pulse-free windows before the tracker resets.

Ports:
- `fclk`, in, 1: 28 MHz clock; the only clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `rdat_n`, in, 1: raw read data from the drive, async, active-low pulses of at least 100 ns.
- `mfm`, in, 1: 1 = MFM windows, 0 = FM windows; quasi-static.
- `vg_rclk`, out, 1: read clock; toggles at each window boundary.
- `vg_rawr`, out, 1: active-high re-timed read pulse, RAWR_W fclk wide.
- `locked`, out, 1: tracker is locked.

## Operation
- **Input path**
  - 3-flop shift `s[2:0]` on `rdat_n`.
  - Detect strobe `det = ~s[1] & s[2]` (falling edge).
  - Flops reset to 1.
- **Window counter**
  - Registers: `cnt[7:0]`; `base` = WIN_MFM or WIN_FM; signed `foff[4:0]`; `per = base + foff`; `C = per>>1`.
  - Each cycle without an accepted pulse: if `cnt == per-1`, then `cnt <= 0` and `vg_rclk` toggles; otherwise `cnt <= cnt+1`.
- **Accepted pulse**
  - A pulse is accepted when `det` is set and the rawr width counter is 0. A `det` while vg_rawr is active is ignored entirely: no correction, no extension.
  - Signed error `err = cnt - C`.
  - Phase correction: `cnt <= cnt + 1 - (err >>> 1)` (arithmetic shift). This always stays within 0..per-1, so no wrap and no rclk toggle occurs in that cycle. The pulse takes priority over the wrap.
  - Frequency: `err >= +3` gives `foff+1`; `err <= -3` gives `foff-1`. foff saturates at ±FOFF_MAX (MFM) or ±2*FOFF_MAX (FM). For FM the thresholds are ±6.
  - vg_rawr is asserted for RAWR_W cycles.
- **Lock tracking**
  - Good pulse: `|err| <= 4` (FM: 8). Increments `good`, saturating at LOCK_CNT. `locked` sets when `good` reaches LOCK_CNT.
  - Bad pulse: `|err| > 12` (FM: 24). Clears `good` and `locked`.
  - Any other error value holds both `good` and `locked`.
- **Idle**
  - `idle` counts window wraps and is cleared by every accepted pulse.
  - At IDLE_WIN: `foff <= 0`, `good <= 0`, `locked <= 0`, and `idle` holds at IDLE_WIN until the next pulse.
- **Mode change**
  - `mfm` is registered. When it differs from its registered copy: `cnt <= 0`, `foff <= 0`, `good <= 0`, `locked <= 0`, `idle <= 0`, rawr counter cleared.
  - A `det` in the same cycle is ignored. `vg_rclk` keeps its level.

## Timing
- **Reset values:** vg_rclk = 0, vg_rawr = 0, locked = 0, cnt = 0, foff = 0, good = 0, idle = 0, s = 3'b111.
- **Reset mid-operation:** all state returns to the reset values immediately, including a vg_rawr pulse in progress. Tracking restarts from cnt = 0 on the first fclk edge after rst falls.
- **Pulse latency:** rdat_n falls, sampled at edge k. vg_rawr rises at edge k+3 and is high for exactly RAWR_W cycles, falling at edge k+3+RAWR_W. Phase and frequency correction take effect at the same edge k+3.
- **Idle rclk (MFM, foff = 0):** toggles every 56 fclk; period 112 fclk = 4 us. FM: 224 fclk.
- **foff update timing:** a change in foff affects `per` from the next cycle. A wrap compare in the same cycle uses the old `per`.
- **Minimum pulse spacing:** the minimum pulse spacing honoured is RAWR_W+1 cycles.

## Test plan
- **Reset and free-run:** assert rst with rdat_n = 1, release, mfm = 1 -> all outputs 0 during reset; vg_rclk toggles every 56 fclk; locked stays 0; after 64 wraps foff = 0.
- **Latency and glitch:** one 3-cycle rdat_n low pulse, then a second pulse 2 cycles after the first is detected -> vg_rawr high for exactly 4 cycles starting at edge k+3; the second pulse produces no rawr extension and no cnt change.
- **Phase acquisition:**
  - Stimulus: pulses every 112 fclk, first detected at cnt = 10.
  - Required: err converges to within ±1 within 6 pulses; locked asserts on the 16th good pulse; vg_rclk edges then sit 28±2 fclk from each rawr rising edge.
- **Frequency tracking:**
  - Pulses every 116 fclk -> foff settles at +2; locked remains 1.
  - Pulses every 130 fclk -> foff saturates at +3; bad pulses keep locked = 0.
- **Mode switch:** mfm 1->0 while locked -> next cycle cnt = 0, locked = 0; vg_rclk half-period becomes 112; FM pulses every 224 fclk relock after 16 pulses.
- **Idle drop and reset mid-pulse:**
  - Lock, then stop pulses for 64 windows -> locked = 0 and foff = 0 at the 64th wrap.
  - Assert rst while vg_rawr is high -> vg_rawr = 0 immediately.
